// File: rtl/regfile_mp.sv
// Multi-port register file: three combinational read ports, two write ports
// (port 1 wins on collision), optional write-to-read bypass, zero register, pending scoreboard.
module regfile_mp #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_EN  = 1,
   parameter int ZERO_IDX = 31,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr0,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data0,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy0,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr_en0,
   input  logic [ADDR_W-1:0] wr_addr0,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic              wr_en1,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              busy_any
);

   localparam int NREGS = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  pending;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_EN != 0) && (a == ADDR_W'(ZERO_IDX));
   endfunction

   // NOTE: the array is a bank of flops, not a RAM macro, so it can and must
   // take the asynchronous clear along with the pending bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         pending <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (!is_zero(ADDR_W'(i))) begin
               // NOTE: non-blocking so every register samples pre-edge inputs
               // regardless of loop order.
               if (wr_en1 && wr_addr1 == ADDR_W'(i))
                  regs[i] <= wr_data1;
               else if (wr_en0 && wr_addr0 == ADDR_W'(i))
                  regs[i] <= wr_data0;

               // A new reservation outranks a completing write to the same register
               if (rsv_en && rsv_addr == ADDR_W'(i))
                  pending[i] <= 1'b1;
               else if ((wr_en1 && wr_addr1 == ADDR_W'(i)) ||
                        (wr_en0 && wr_addr0 == ADDR_W'(i)))
                  pending[i] <= 1'b0;
            end
         end
      end
   end

   logic [ADDR_W-1:0] ra   [3];
   logic [DATA_W-1:0] rdat [3];
   logic              rbsy [3];
   logic              bypass_ok;

   assign ra[0] = rd_addr0;
   assign ra[1] = rd_addr1;
   assign ra[2] = rd_addr2;

   // Bypass is suppressed while reset is held so outputs read zero immediately
   assign bypass_ok = (BYPASS != 0) && !reset;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         // NOTE: defaults first on every path keeps this purely combinational.
         rdat[k] = regs[ra[k]];
         rbsy[k] = pending[ra[k]];
         if (bypass_ok) begin
            if (wr_en1 && wr_addr1 == ra[k]) begin
               rdat[k] = wr_data1;
               rbsy[k] = 1'b0;
            end else if (wr_en0 && wr_addr0 == ra[k]) begin
               rdat[k] = wr_data0;
               rbsy[k] = 1'b0;
            end
         end
         if (is_zero(ra[k])) begin
            rdat[k] = '0;
            rbsy[k] = 1'b0;
         end
      end
   end

   assign rd_data0 = rdat[0];
   assign rd_data1 = rdat[1];
   assign rd_data2 = rdat[2];
   assign rd_busy0 = rbsy[0];
   assign rd_busy1 = rbsy[1];
   assign rd_busy2 = rbsy[2];
   assign busy_any = |pending;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default instance (64b, zero reg, bypass) and a small
// 32b/8-entry instance without zero reg or bypass, both checked against array models.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [4:0]  rd_addr0, rd_addr1, rd_addr2, wr_addr0, wr_addr1, rsv_addr;
   logic [63:0] wr_data0, wr_data1;
   logic        wr_en0, wr_en1, rsv_en;

   logic [63:0] a_rd_data0, a_rd_data1, a_rd_data2;
   logic        a_rd_busy0, a_rd_busy1, a_rd_busy2, a_busy_any;
   logic [31:0] b_rd_data0, b_rd_data1, b_rd_data2;
   logic        b_rd_busy0, b_rd_busy1, b_rd_busy2, b_busy_any;

   regfile_mp dut_a (
      .clk(clk), .reset(reset),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data0(a_rd_data0), .rd_data1(a_rd_data1), .rd_data2(a_rd_data2),
      .rd_busy0(a_rd_busy0), .rd_busy1(a_rd_busy1), .rd_busy2(a_rd_busy2),
      .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_any(a_busy_any)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(3), .ZERO_EN(0), .ZERO_IDX(7), .BYPASS(0)) dut_b (
      .clk(clk), .reset(reset),
      .rd_addr0(rd_addr0[2:0]), .rd_addr1(rd_addr1[2:0]), .rd_addr2(rd_addr2[2:0]),
      .rd_data0(b_rd_data0), .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
      .rd_busy0(b_rd_busy0), .rd_busy1(b_rd_busy1), .rd_busy2(b_rd_busy2),
      .wr_en0(wr_en0), .wr_addr0(wr_addr0[2:0]), .wr_data0(wr_data0[31:0]),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1[2:0]), .wr_data1(wr_data1[31:0]),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr[2:0]), .busy_any(b_busy_any)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit cmp_on = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference state: contents and reservation flags per architectural register
   logic [63:0] ma [32];
   bit          pa [32];
   logic [31:0] mb [8];
   bit          pb [8];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         foreach (ma[i]) begin ma[i] = '0; pa[i] = 1'b0; end
         foreach (mb[i]) begin mb[i] = '0; pb[i] = 1'b0; end
      end else begin
         // Apply port 0, then port 1 so port 1 naturally overwrites on collision;
         // the reservation is applied last so it survives a same-address write.
         if (wr_en0 && wr_addr0 != 5'd31) begin ma[wr_addr0] = wr_data0; pa[wr_addr0] = 1'b0; end
         if (wr_en1 && wr_addr1 != 5'd31) begin ma[wr_addr1] = wr_data1; pa[wr_addr1] = 1'b0; end
         if (rsv_en && rsv_addr != 5'd31) pa[rsv_addr] = 1'b1;
         if (wr_en0) begin mb[wr_addr0[2:0]] = wr_data0[31:0]; pb[wr_addr0[2:0]] = 1'b0; end
         if (wr_en1) begin mb[wr_addr1[2:0]] = wr_data1[31:0]; pb[wr_addr1[2:0]] = 1'b0; end
         if (rsv_en) pb[rsv_addr[2:0]] = 1'b1;
      end
   end

   function automatic void exp_a(input logic [4:0] a, output logic [63:0] d, output logic b);
      d = ma[a];
      b = pa[a];
      if (wr_en1 && wr_addr1 == a) begin d = wr_data1; b = 1'b0; end
      else if (wr_en0 && wr_addr0 == a) begin d = wr_data0; b = 1'b0; end
      if (a == 5'd31 || reset) begin d = '0; b = 1'b0; end
   endfunction

   function automatic void exp_b(input logic [4:0] a, output logic [63:0] d, output logic b);
      d = {32'd0, mb[a[2:0]]};
      b = pb[a[2:0]];
      if (reset) begin d = '0; b = 1'b0; end
   endfunction

   function automatic logic any_a();
      logic r = 1'b0;
      foreach (pa[i]) r |= pa[i];
      return r && !reset;
   endfunction

   function automatic logic any_b();
      logic r = 1'b0;
      foreach (pb[i]) r |= pb[i];
      return r && !reset;
   endfunction

   task automatic cmp_a(input int k, input logic [4:0] a, input logic [63:0] d, input logic b);
      logic [63:0] ed;
      logic        eb;
      exp_a(a, ed, eb);
      check($sformatf("a_rd_data%0d[x%0d]", k, a), d, ed);
      check($sformatf("a_rd_busy%0d[x%0d]", k, a), 64'(b), 64'(eb));
   endtask

   task automatic cmp_b(input int k, input logic [4:0] a, input logic [63:0] d, input logic b);
      logic [63:0] ed;
      logic        eb;
      exp_b(a, ed, eb);
      check($sformatf("b_rd_data%0d[r%0d]", k, a[2:0]), d, ed);
      check($sformatf("b_rd_busy%0d[r%0d]", k, a[2:0]), 64'(b), 64'(eb));
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         cmp_a(0, rd_addr0, a_rd_data0, a_rd_busy0);
         cmp_a(1, rd_addr1, a_rd_data1, a_rd_busy1);
         cmp_a(2, rd_addr2, a_rd_data2, a_rd_busy2);
         cmp_b(0, rd_addr0, 64'(b_rd_data0), b_rd_busy0);
         cmp_b(1, rd_addr1, 64'(b_rd_data1), b_rd_busy1);
         cmp_b(2, rd_addr2, 64'(b_rd_data2), b_rd_busy2);
         check("a_busy_any", 64'(a_busy_any), 64'(any_a()));
         check("b_busy_any", 64'(b_busy_any), 64'(any_b()));
      end
   end

   task automatic idle();
      wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
      wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
      rsv_en = 1'b0; rsv_addr = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask

   function automatic logic [4:0] rnd_addr();
      case ($urandom_range(0, 3))
         0:       return 5'd31;
         1, 2:    return 5'($urandom_range(0, 9));
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   initial begin
      idle();
      rd_addr0 = '0; rd_addr1 = '0; rd_addr2 = '0;
      #1 reset = 1'b1;
      cmp_on = 1'b1;
      #2;
      check("reset_rd_data0", a_rd_data0, 64'd0);
      check("reset_busy_any", 64'(a_busy_any), 64'd0);
      @(posedge clk); #1 reset = 1'b0;

      // Write x3 on port 0: bypass same cycle, stored next cycle
      cyc(); wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 64'hDEAD_BEEF_0000_0001; rd_addr0 = 5'd3;
      #2 check("bypass_x3", a_rd_data0, 64'hDEAD_BEEF_0000_0001);
      check("b_nobypass_r3", 64'(b_rd_data0), 64'd0);
      cyc(); rd_addr0 = 5'd3;
      #2 check("stored_x3", a_rd_data0, 64'hDEAD_BEEF_0000_0001);
      check("b_stored_r3", 64'(b_rd_data0), 64'h1);

      // Collision on x7: port 1 data wins
      cyc(); wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 64'h11;
      wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 64'h22; rd_addr1 = 5'd7;
      #2 check("collide_bypass_x7", a_rd_data1, 64'h22);
      cyc(); rd_addr1 = 5'd7;
      #2 check("collide_x7", a_rd_data1, 64'h22);
      check("b_collide_r7", 64'(b_rd_data1), 64'h22);

      // Zero register ignores write and reserve; in the small instance index 7 is ordinary
      cyc(); wr_en0 = 1'b1; wr_addr0 = 5'd31; wr_data0 = 64'hFF; rsv_en = 1'b1; rsv_addr = 5'd31;
      rd_addr2 = 5'd31;
      #2 check("xzr_data_same", a_rd_data2, 64'd0);
      check("xzr_busy_same", 64'(a_rd_busy2), 64'd0);
      cyc(); rd_addr2 = 5'd31;
      #2 check("xzr_data", a_rd_data2, 64'd0);
      check("xzr_busy", 64'(a_rd_busy2), 64'd0);
      check("xzr_busy_any", 64'(a_busy_any), 64'd0);
      check("b_r7_data", 64'(b_rd_data2), 64'hFF);
      check("b_r7_busy", 64'(b_rd_busy2), 64'd1);

      // Scoreboard on x9
      cyc(); rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr1 = 5'd9;
      #2 check("rsv_x9_not_yet", 64'(a_rd_busy1), 64'd0);
      cyc(); rd_addr1 = 5'd9;
      #2 check("rsv_x9_busy", 64'(a_rd_busy1), 64'd1);
      check("rsv_x9_busy_any", 64'(a_busy_any), 64'd1);
      cyc(); wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 64'h42; rd_addr1 = 5'd9;
      #2 check("wb_x9_busy_same", 64'(a_rd_busy1), 64'd0);
      check("wb_x9_data_same", a_rd_data1, 64'h42);
      cyc(); rd_addr1 = 5'd9;
      #2 check("wb_x9_busy", 64'(a_rd_busy1), 64'd0);
      check("wb_x9_busy_any", 64'(a_busy_any), 64'd0);
      cyc(); wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 64'h43; rsv_en = 1'b1; rsv_addr = 5'd9;
      cyc(); rd_addr1 = 5'd9;
      #2 check("wr_rsv_x9_busy", 64'(a_rd_busy1), 64'd1);
      check("wr_rsv_x9_data", a_rd_data1, 64'h43);

      // Fill x0..x30, reserve x5, then reset mid-cycle with a write in flight
      for (int i = 0; i < 31; i++) begin
         cyc(); wr_en0 = 1'b1; wr_addr0 = 5'(i); wr_data0 = 64'(i) * 64'h0101_0101_0101_0101 + 64'h1;
      end
      cyc(); rsv_en = 1'b1; rsv_addr = 5'd5;
      cyc(); rd_addr0 = 5'd5; rd_addr1 = 5'd3; rd_addr2 = 5'd30;
      #2 check("pre_reset_busy_x5", 64'(a_rd_busy0), 64'd1);
      check("pre_reset_x30", a_rd_data2, 64'h1E1E_1E1E_1E1E_1E1F);
      wr_en1 = 1'b1; wr_addr1 = 5'd3; wr_data1 = 64'h77;
      reset = 1'b1;
      #1 check("reset_x5_data", a_rd_data0, 64'd0);
      check("reset_x5_busy", 64'(a_rd_busy0), 64'd0);
      check("reset_x3_data", a_rd_data1, 64'd0);
      check("reset_x30_data", a_rd_data2, 64'd0);
      check("reset_busy_any_mid", 64'(a_busy_any), 64'd0);
      @(posedge clk); #1 reset = 1'b0; idle();
      #2 check("post_reset_x3", a_rd_data1, 64'd0);

      // Randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         cyc();
         reset    = ($urandom_range(0, 299) == 0);
         wr_en0   = $urandom_range(0, 1);
         wr_addr0 = rnd_addr();
         wr_data0 = {$urandom, $urandom};
         wr_en1   = $urandom_range(0, 1);
         wr_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr0 : rnd_addr();
         wr_data1 = {$urandom, $urandom};
         rsv_en   = ($urandom_range(0, 2) == 0);
         rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr1 : rnd_addr();
         rd_addr0 = ($urandom_range(0, 2) == 0) ? wr_addr0 : rnd_addr();
         rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr1 : rnd_addr();
         rd_addr2 = rnd_addr();
      end
      cyc();
      reset = 1'b0;
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
